// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU: round-robin grant,
// one execute cycle, then the captured result is returned over valid/ready.
module alu_share_arbiter #(
    parameter int data_width = 16,
    parameter int func_width = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [data_width-1:0] req0_A,
    input  logic [data_width-1:0] req0_B,
    input  logic [func_width-1:0] req0_func,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [data_width-1:0] req1_A,
    input  logic [data_width-1:0] req1_B,
    input  logic [func_width-1:0] req1_func,
    output logic [data_width-1:0] alu_A,
    output logic [data_width-1:0] alu_B,
    output logic [func_width-1:0] alu_func,
    input  logic [data_width-1:0] alu_C,
    input  logic                  alu_ovf,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [data_width-1:0] rsp_C,
    output logic                  rsp_ovf,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [data_width-1:0] a_q, a_d;
    logic [data_width-1:0] b_q, b_d;
    logic [func_width-1:0] func_q, func_d;
    logic                  id_q, id_d;
    logic [data_width-1:0] rsp_c_q, rsp_c_d;
    logic                  rsp_ovf_q, rsp_ovf_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  sticky_q, sticky_d;
    logic [15:0]           count_q, count_d;

    logic grant;
    logic in_idle;

    // On contention the requester that did not win last time gets the ALU.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        in_idle    = (state_q == IDLE);
        req0_ready = in_idle && req0_valid && !grant;
        req1_ready = in_idle && req1_valid && grant;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        func_d       = func_q;
        id_d         = id_q;
        rsp_c_d      = rsp_c_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_valid_d  = rsp_valid_q;
        sticky_d     = ovf_clr ? 1'b0 : sticky_q;
        count_d      = count_q;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    a_d     = grant ? req1_A    : req0_A;
                    b_d     = grant ? req1_B    : req0_B;
                    func_d  = grant ? req1_func : req0_func;
                    id_d    = grant;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_c_d     = alu_C;
                rsp_ovf_d   = alu_ovf;
                // A capture with overflow overrides a simultaneous clear.
                if (alu_ovf) begin
                    sticky_d = 1'b1;
                end
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = id_q;
                    count_d      = count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            func_q       <= '0;
            id_q         <= 1'b0;
            rsp_c_q      <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            sticky_q     <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            func_q       <= func_d;
            id_q         <= id_d;
            rsp_c_q      <= rsp_c_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_valid_q  <= rsp_valid_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_func   = func_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_C      = rsp_c_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign ovf_sticky = sticky_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, directed corner sequences and
// random traffic, all checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic [3:0]  req0_func = '0, req1_func = '0;
    logic [15:0] alu_A, alu_B, alu_C;
    logic [3:0]  alu_func;
    logic        alu_ovf;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_ovf;
    logic [15:0] rsp_C;
    logic        ovf_sticky, ovf_clr = 1'b0;
    logic [15:0] op_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.data_width(16), .func_width(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_A(req1_A), .req1_B(req1_B), .req1_func(req1_func),
        .alu_A(alu_A), .alu_B(alu_B), .alu_func(alu_func),
        .alu_C(alu_C), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_C(rsp_C), .rsp_ovf(rsp_ovf),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .op_count(op_count)
    );

    // Stand-in for the shared ALU: add/sub with signed overflow, pass A, else XOR.
    function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
        logic [15:0] c;
        logic        o;
        case (f)
            4'd0: begin c = a + b; o = (a[15] == b[15]) && (c[15] != a[15]); end
            4'd1: begin c = a - b; o = (a[15] != b[15]) && (c[15] != a[15]); end
            4'd2: begin c = a;     o = 1'b0; end
            default: begin c = a ^ b; o = 1'b0; end
        endcase
        return {o, c};
    endfunction

    assign {alu_ovf, alu_C} = alu_ref(alu_A, alu_B, alu_func);

    // Transaction-level reference: at most one operation in flight; it spends
    // one cycle at the ALU, then waits for the consumer.
    bit          m_pend;
    bit          m_at_alu;
    bit          m_id;
    bit          m_last;
    logic [15:0] m_a, m_b, m_rc;
    logic [3:0]  m_f;
    bit          m_rovf;
    bit          m_sticky;
    logic [15:0] m_count;

    bit          g_hs0, g_hs1, g_rsp_hs, g_rsp_id, g_rsp_ovf;
    logic [15:0] g_rsp_c;

    task automatic model_reset();
        m_pend = 0; m_at_alu = 0; m_id = 0; m_last = 1;
        m_a = '0; m_b = '0; m_f = '0; m_rc = '0; m_rovf = 0;
        m_sticky = 0; m_count = '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at negedge+1 with inputs already driven; returns at the next negedge+1.
    task automatic cycle();
        bit er0, er1, ev;
        #1;
        er0 = !m_pend && req0_valid && (!req1_valid || m_last);
        er1 = !m_pend && req1_valid && (!req0_valid || !m_last);
        ev  = m_pend && !m_at_alu;
        check("req0_ready", req0_ready, er0);
        check("req1_ready", req1_ready, er1);
        check("rsp_valid", rsp_valid, ev);
        if (ev) check("rsp_id", rsp_id, m_id);
        check("rsp_C", rsp_C, m_rc);
        check("rsp_ovf", rsp_ovf, m_rovf);
        check("alu_A", alu_A, m_a);
        check("alu_B", alu_B, m_b);
        check("alu_func", alu_func, m_f);
        check("ovf_sticky", ovf_sticky, m_sticky);
        check("op_count", op_count, m_count);
        g_hs0 = req0_valid && req0_ready;
        g_hs1 = req1_valid && req1_ready;
        g_rsp_hs = rsp_valid && rsp_ready;
        if (g_rsp_hs) begin
            g_rsp_id = rsp_id; g_rsp_c = rsp_C; g_rsp_ovf = rsp_ovf;
        end
        if (ovf_clr) m_sticky = 0;
        if (m_pend && m_at_alu) begin
            {m_rovf, m_rc} = alu_ref(m_a, m_b, m_f);
            if (m_rovf) m_sticky = 1;
            m_at_alu = 0;
        end else if (m_pend) begin
            if (rsp_ready) begin
                m_pend = 0; m_last = m_id; m_count = m_count + 16'd1;
            end
        end else if (er0 || er1) begin
            m_pend = 1; m_at_alu = 1; m_id = er1;
            m_a = er1 ? req1_A : req0_A;
            m_b = er1 ? req1_B : req0_B;
            m_f = er1 ? req1_func : req0_func;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input int bp, input bit clr_cap);
        bit acc;
        int n;
        if (id) begin req1_valid = 1; req1_A = a; req1_B = b; req1_func = f; end
        else    begin req0_valid = 1; req0_A = a; req0_B = b; req0_func = f; end
        rsp_ready = (bp == 0);
        acc = 0; n = 0;
        while (!acc && n < 10) begin
            cycle();
            acc = id ? g_hs1 : g_hs0;
            n++;
        end
        check("accept_seen", acc, 1);
        if (id) req1_valid = 0; else req0_valid = 0;
        ovf_clr = clr_cap;
        cycle();
        ovf_clr = 0;
        g_rsp_hs = 0; n = 0;
        while (!g_rsp_hs && n < bp + 10) begin
            rsp_ready = (n >= bp);
            cycle();
            n++;
        end
        check("rsp_seen", g_rsp_hs, 1);
        rsp_ready = 0;
    endtask

    typedef struct {
        bit          id;
        logic [15:0] a, b;
        logic [3:0]  f;
        logic [15:0] exp_c;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit order_ok;
        int n, nrsp, r0cnt, r1cnt;
        bit ids[4];

        vecs[0] = '{0, 16'h1234, 16'h0000, 4'd2, 16'h1234, 0};
        vecs[1] = '{1, 16'h0005, 16'h0003, 4'd0, 16'h0008, 0};
        vecs[2] = '{0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1};
        vecs[3] = '{1, 16'h8000, 16'h0001, 4'd1, 16'h7FFF, 1};
        vecs[4] = '{0, 16'h00F0, 16'h0F0F, 4'd9, 16'h0FFF, 0};
        vecs[5] = '{1, 16'hFFFF, 16'h0000, 4'd2, 16'hFFFF, 0};

        // Power-on reset.
        #2 reset_n = 0;
        #1;
        model_reset();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_A", alu_A, 0);
        @(negedge clk); #1;
        reset_n = 1;

        // Single operations from the vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].f, 0, 0);
            check("vec_id", g_rsp_id, vecs[i].id);
            check("vec_C", g_rsp_c, vecs[i].exp_c);
            check("vec_ovf", g_rsp_ovf, vecs[i].exp_ovf);
        end
        check("vec_count", op_count, 6);

        // Overflow sticky: clear on capture edge of an overflowing op loses.
        ovf_clr = 1; cycle(); ovf_clr = 0;
        check("sticky_cleared", ovf_sticky, 0);
        run_op(0, 16'h7FFF, 16'h0001, 4'd0, 0, 0);
        check("sticky_op1_ovf", g_rsp_ovf, 1);
        check("sticky_op1", ovf_sticky, 1);
        run_op(1, 16'h8000, 16'h8000, 4'd0, 0, 1);
        check("sticky_op2_ovf", g_rsp_ovf, 1);
        check("sticky_set_wins", ovf_sticky, 1);
        ovf_clr = 1; cycle(); ovf_clr = 0;
        check("sticky_clr_alone", ovf_sticky, 0);

        // Backpressure with a competing requester waiting.
        req1_valid = 1; req1_A = 16'h0101; req1_B = 16'h0202; req1_func = 4'd0;
        run_op(0, 16'hFFFF, 16'h1111, 4'd2, 5, 0);
        check("bp_C", g_rsp_c, 16'hFFFF);
        check("bp_id", g_rsp_id, 0);
        run_op(1, 16'h0101, 16'h0202, 4'd0, 0, 0);
        check("bp_req1_C", g_rsp_c, 16'h0303);

        // Counter wrap.
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        m_count = 16'hFFFF;
        run_op(0, 16'h0001, 16'h0001, 4'd0, 0, 0);
        check("wrap_count", op_count, 0);

        // Reset in the middle of EXEC aborts the operation.
        req0_valid = 1; req0_A = 16'hABCD; req0_B = 16'h1; req0_func = 4'd2;
        g_hs0 = 0; n = 0;
        while (!g_hs0 && n < 10) begin cycle(); n++; end
        check("mid_accept", g_hs0, 1);
        req0_valid = 0;
        reset_n = 0;
        #1;
        model_reset();
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_alu_A", alu_A, 0);
        check("mid_alu_func", alu_func, 0);
        check("mid_rsp_C", rsp_C, 0);
        check("mid_count", op_count, 0);
        check("mid_sticky", ovf_sticky, 0);
        @(negedge clk); #1;
        reset_n = 1;
        rsp_ready = 1;
        for (int k = 0; k < 4; k++) cycle();

        // Fairness: both requesters continuously valid.
        req0_valid = 1; req0_A = 16'h0010; req0_B = 16'h0; req0_func = 4'd2;
        req1_valid = 1; req1_A = 16'h0020; req1_B = 16'h0; req1_func = 4'd2;
        nrsp = 0; n = 0; r0cnt = 0; r1cnt = 0;
        while (nrsp < 4 && n < 60) begin
            cycle();
            if (g_hs0) begin r0cnt++; req0_A = req0_A + 16'd1; end
            if (g_hs1) begin r1cnt++; req1_A = req1_A + 16'd1; end
            if (g_rsp_hs) begin ids[nrsp] = g_rsp_id; nrsp++; end
            n++;
        end
        req0_valid = 0; req1_valid = 0;
        check("fair_nrsp", nrsp, 4);
        order_ok = (nrsp == 4) && !ids[0] && ids[1] && !ids[2] && ids[3];
        check("fair_order", order_ok, 1);
        check("fair_r0", r0cnt, 2);
        check("fair_r1", r1cnt, 2);
        check("fair_count", op_count, 4);

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            if (req0_valid && !g_hs0) begin
                if ($urandom_range(9) == 0) req0_valid = 0;
            end else if ($urandom_range(2) == 0) begin
                req0_valid = 1; req0_A = 16'($urandom); req0_B = 16'($urandom);
                req0_func = 4'($urandom_range(15));
            end else begin
                req0_valid = 0;
            end
            if (req1_valid && !g_hs1) begin
                if ($urandom_range(9) == 0) req1_valid = 0;
            end else if ($urandom_range(2) == 0) begin
                req1_valid = 1; req1_A = 16'($urandom); req1_B = 16'($urandom);
                req1_func = 4'($urandom_range(15));
            end else begin
                req1_valid = 0;
            end
            rsp_ready = ($urandom_range(3) != 0);
            ovf_clr = ($urandom_range(7) == 0);
            cycle();
        end
        req0_valid = 0; req1_valid = 0; ovf_clr = 0; rsp_ready = 1;
        for (int k = 0; k < 6; k++) cycle();
        check("drain_idle", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
